pcm_ddram_fetch: RTL and testbench
==================================

Name: pcm_ddram_fetch

Overview:
- Single-channel DDR3 responder serving the sound board's PCM ROM requests and the ROM-download write path.
- Requester side: byte-address request / one-cycle ready handshake returning a 64-bit word; requester selects the byte with addr[2:0].
- DDRAM side: drives the MiSTer Avalon-style DDRAM port with single-beat reads and writes.
- Holds a one-word read cache so sequential PCM byte fetches within a 64-bit word cost no DDR3 access.

Parameters:
- BASE_ADDR, 29'h0300000: DDRAM 64-bit word address of PCM region start.
- ADDR_W, 18: width of requester byte address.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ch_addr  in  ADDR_W  read byte address; sampled with ch_req.
- ch_req  in  1  one-cycle read request pulse.
- ch_dout  out  64  returned word; held stable until next ch_ready.
- ch_ready  out  1  one-cycle pulse; ch_dout valid.
- wr_addr  in  ADDR_W  download byte address.
- wr_data  in  8  download byte.
- wr_en  in  1  one-cycle byte write strobe.
- wr_busy  out  1  write pending; drives ioctl_wait.
- DDRAM_BUSY  in  1  controller stall.
- DDRAM_BURSTCNT  out  8  constant 8'd1.
- DDRAM_ADDR  out  29  word address.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.

Behaviour:
- Reset: all outputs 0 except DDRAM_BURSTCNT=1; cache valid=0; pending flags cleared; FSM=IDLE. Reset asserted mid-transaction drops RD/WE immediately and abandons the access. DOUT_READY received in IDLE is ignored.
- Word address: DDRAM_ADDR = BASE_ADDR + addr[ADDR_W-1:3], zero-extended to 29 bits, modulo 2^29.
- Request capture: ch_req latches ch_addr into a one-deep pending-read register in any state; a later ch_req before service overwrites it (latest wins). wr_en latches wr_addr/wr_data into the pending-write register and sets wr_busy the next cycle. wr_en while wr_busy=1 is ignored.
- Cache hit: pending read in IDLE with valid=1 and tag==ch_addr[ADDR_W-1:3]. ch_ready pulses the cycle after ch_req; ch_dout = cached word; no DDRAM activity.
- FSM states: IDLE, RD_CMD, RD_WAIT, WR_CMD.
  - IDLE: pending write takes priority → WR_CMD. Else pending read miss → RD_CMD. Else hit → ch_ready.
  - RD_CMD: DDRAM_RD=1 with address held. Stays while DDRAM_BUSY=1. At the edge where BUSY=0, drop RD → RD_WAIT.
  - RD_WAIT: on DDRAM_DOUT_READY, register DOUT into ch_dout and cache, set tag, valid=1, pulse ch_ready next cycle → IDLE.
  - WR_CMD: DDRAM_WE=1, DIN = wr_data replicated in all 8 lanes, BE = one-hot of wr_addr[2:0]. Held while BUSY=1; on BUSY=0 edge, drop WE, clear wr_busy, → IDLE.
- Miss latency with BUSY=0: RD asserted cycle after ch_req for exactly 1 cycle. ch_ready 1 cycle after DOUT_READY.
- Coherency: any write whose word address equals the tag clears valid in the cycle the write is accepted.
- A read pending behind a write is served after the write completes; the hit check uses the post-write valid state.
- RD and WE are never both 1. ch_ready never pulses on consecutive cycles for a single request.

Test Plan:
- Miss: ch_addr=0x00005, BUSY=0 → RD one cycle, DDRAM_ADDR=0x0300000. DOUT_READY with DOUT=64'h1122334455667788 → ch_ready next cycle, ch_dout equal to that word.
- Hit: after the miss, ch_addr=0x00007 → ch_ready 1 cycle later, same ch_dout, RD stays 0.
- Stall: BUSY held 1 for 5 cycles during RD_CMD → RD held 1 for 6 cycles with stable DDRAM_ADDR, then single ch_ready.
- Write: wr_addr=0x00003, wr_data=8'hA5 → WE one cycle, BE=8'b00001000, DIN=64'hA5A5A5A5A5A5A5A5, wr_busy high then low. Following ch_addr=0x00000 misses and issues RD (cache invalidated).
- Simultaneous wr_en and ch_req in IDLE → WE completes first, then RD; exactly one ch_ready.
- Reset: reset_n low during RD_WAIT → RD=0, ch_ready=0, valid=0. A late DOUT_READY after release produces no ch_ready.

Source files
------------

// File: rtl/pcm_ddram_fetch.sv
// PCM ROM fetch responder on the MiSTer DDRAM port: single-beat reads with a
// one-word read cache, plus the byte-wide ROM download write path.
module pcm_ddram_fetch #(
  parameter logic [28:0] BASE_ADDR = 29'h0300000,
  parameter int          ADDR_W    = 18
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ch_addr,
  input  logic              ch_req,
  output logic [63:0]       ch_dout,
  output logic              ch_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              wr_busy,
  input  logic              DDRAM_BUSY,
  output logic [7:0]        DDRAM_BURSTCNT,
  output logic [28:0]       DDRAM_ADDR,
  input  logic [63:0]       DDRAM_DOUT,
  input  logic              DDRAM_DOUT_READY,
  output logic              DDRAM_RD,
  output logic [63:0]       DDRAM_DIN,
  output logic [7:0]        DDRAM_BE,
  output logic              DDRAM_WE
);

  localparam int TAG_W = ADDR_W - 3;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

  state_t              state_q, state_d;
  logic                pend_rd_q, pend_rd_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_busy_q, wr_busy_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [63:0]         cache_q, cache_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    fetch_tag_q, fetch_tag_d;
  logic                valid_q, valid_d;
  logic [63:0]         dout_q, dout_d;
  logic                ready_q, ready_d;
  logic [28:0]         ddr_addr_q, ddr_addr_d;
  logic                rd_q, rd_d;
  logic                we_q, we_d;
  logic [63:0]         din_q, din_d;
  logic [7:0]          be_q, be_d;

  logic                wr_acc_s;
  logic                wr_v_s;
  logic                rd_v_s;
  logic [ADDR_W-1:0]   wa_s;
  logic [7:0]          wd_s;
  logic [ADDR_W-1:0]   ra_s;

  function automatic logic [28:0] word_addr(input logic [ADDR_W-1:0] a);
    logic [28:0] w;
    w = 29'(a[ADDR_W-1:3]);
    return BASE_ADDR + w;
  endfunction

  // Next-state, request capture and command generation.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    rd_addr_d   = rd_addr_q;
    wr_busy_d   = wr_busy_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cache_d     = cache_q;
    tag_d       = tag_q;
    fetch_tag_d = fetch_tag_q;
    valid_d     = valid_q;
    dout_d      = dout_q;
    ready_d     = 1'b0;
    ddr_addr_d  = ddr_addr_q;
    rd_d        = rd_q;
    we_d        = we_q;
    din_d       = din_q;
    be_d        = be_q;

    // A fresh request is visible in the same cycle so IDLE can act on it at once.
    wr_acc_s = wr_en & ~wr_busy_q;
    wr_v_s   = wr_busy_q | wr_acc_s;
    wa_s     = wr_busy_q ? wr_addr_q : wr_addr;
    wd_s     = wr_busy_q ? wr_data_q : wr_data;
    rd_v_s   = ch_req | pend_rd_q;
    ra_s     = ch_req ? ch_addr : rd_addr_q;

    if (ch_req) begin
      pend_rd_d = 1'b1;
      rd_addr_d = ch_addr;
    end else begin
      pend_rd_d = pend_rd_q;
    end

    if (wr_acc_s) begin
      wr_busy_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      if (valid_q && (wr_addr[ADDR_W-1:3] == tag_q)) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      wr_busy_d = wr_busy_q;
    end

    case (state_q)
      IDLE: begin
        if (wr_v_s) begin
          state_d    = WR_CMD;
          we_d       = 1'b1;
          ddr_addr_d = word_addr(wa_s);
          din_d      = {8{wd_s}};
          be_d       = 8'b0000_0001 << wa_s[2:0];
        end else if (rd_v_s) begin
          pend_rd_d = 1'b0;
          if (valid_q && (ra_s[ADDR_W-1:3] == tag_q)) begin
            ready_d = 1'b1;
            dout_d  = cache_q;
          end else begin
            state_d     = RD_CMD;
            rd_d        = 1'b1;
            ddr_addr_d  = word_addr(ra_s);
            fetch_tag_d = ra_s[ADDR_W-1:3];
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_CMD: begin
        if (!DDRAM_BUSY) begin
          rd_d    = 1'b0;
          state_d = RD_WAIT;
        end else begin
          rd_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          dout_d  = DDRAM_DOUT;
          cache_d = DDRAM_DOUT;
          tag_d   = fetch_tag_q;
          // A write already queued to this word makes the fetched data stale.
          valid_d = !(wr_v_s && (wa_s[ADDR_W-1:3] == fetch_tag_q));
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_CMD: begin
        if (!DDRAM_BUSY) begin
          we_d      = 1'b0;
          wr_busy_d = 1'b0;
          state_d   = IDLE;
        end else begin
          we_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_rd_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_busy_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      cache_q     <= 64'h0;
      tag_q       <= '0;
      fetch_tag_q <= '0;
      valid_q     <= 1'b0;
      dout_q      <= 64'h0;
      ready_q     <= 1'b0;
      ddr_addr_q  <= 29'h0;
      rd_q        <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= 64'h0;
      be_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      rd_addr_q   <= rd_addr_d;
      wr_busy_q   <= wr_busy_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cache_q     <= cache_d;
      tag_q       <= tag_d;
      fetch_tag_q <= fetch_tag_d;
      valid_q     <= valid_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      ddr_addr_q  <= ddr_addr_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      din_q       <= din_d;
      be_q        <= be_d;
    end
  end

  assign ch_dout        = dout_q;
  assign ch_ready       = ready_q;
  assign wr_busy        = wr_busy_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_pcm_ddram_fetch.sv
// Directed plus randomized bench for pcm_ddram_fetch against a memory/cache
// reference model held in the bench.
module tb_pcm_ddram_fetch;

  localparam logic [28:0] BASE = 29'h0300000;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [17:0] ch_addr;
  logic        ch_req;
  logic [63:0] ch_dout;
  logic        ch_ready;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        wr_busy;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  pcm_ddram_fetch dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ch_addr(ch_addr), .ch_req(ch_req), .ch_dout(ch_dout), .ch_ready(ch_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  int n_pass = 0;
  int n_chk  = 0;
  int ready_cnt = 0;
  int both_cnt  = 0;

  // Reference model: DDR word store plus the one-word cache state.
  logic [63:0] mem [logic [28:0]];
  logic        m_valid = 1'b0;
  logic [14:0] m_tag   = 15'h0;

  always @(negedge clk_sys) begin
    if (ch_ready) ready_cnt <= ready_cnt + 1;
    if (DDRAM_RD && DDRAM_WE) both_cnt <= both_cnt + 1;
  end

  function automatic logic [63:0] mem_rd(input logic [28:0] w);
    if (!mem.exists(w)) mem[w] = {$urandom, $urandom};
    return mem[w];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // From the cycle where RD is first seen high: stall, respond, check data.
  task automatic rd_finish(input logic [17:0] a, input int b, input int lat, input logic [63:0] exp);
    logic [28:0] wa;
    wa = BASE + 29'(a >> 3);
    for (int k = 0; k < b; k++) begin
      @(negedge clk_sys);
      chk("rd_stall_rd", DDRAM_RD, 64'd1);
      chk("rd_stall_addr", DDRAM_ADDR, wa);
      chk("rd_stall_ready", ch_ready, 64'd0);
      if (k == b - 1) DDRAM_BUSY = 1'b0;
    end
    @(negedge clk_sys);
    chk("rd_dropped", DDRAM_RD, 64'd0);
    chk("rd_wait_ready", ch_ready, 64'd0);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk_sys);
      chk("rd_lat_ready", ch_ready, 64'd0);
    end
    DDRAM_DOUT = exp;
    DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT = {$urandom, $urandom};
    chk("fill_ready", ch_ready, 64'd1);
    chk("fill_dout", ch_dout, exp);
    @(negedge clk_sys);
    chk("fill_ready_pulse", ch_ready, 64'd0);
    chk("fill_dout_held", ch_dout, exp);
    chk("fill_no_rd", DDRAM_RD, 64'd0);
    m_valid = 1'b1;
    m_tag   = a[17:3];
  endtask

  task automatic rd_txn(input logic [17:0] a, input int b, input int lat);
    logic [28:0] wa;
    logic [63:0] exp;
    logic        hit;
    wa  = BASE + 29'(a >> 3);
    exp = mem_rd(wa);
    hit = m_valid && (m_tag == a[17:3]);
    ch_addr = a;
    ch_req = 1'b1;
    DDRAM_BUSY = (b > 0);
    @(negedge clk_sys);
    ch_req = 1'b0;
    if (hit) begin
      chk("hit_ready", ch_ready, 64'd1);
      chk("hit_dout", ch_dout, exp);
      chk("hit_no_rd", DDRAM_RD, 64'd0);
      @(negedge clk_sys);
      chk("hit_ready_pulse", ch_ready, 64'd0);
      chk("hit_no_rd2", DDRAM_RD, 64'd0);
      DDRAM_BUSY = 1'b0;
    end else begin
      chk("miss_rd", DDRAM_RD, 64'd1);
      chk("miss_addr", DDRAM_ADDR, wa);
      chk("miss_no_ready", ch_ready, 64'd0);
      rd_finish(a, b, lat, exp);
    end
  endtask

  task automatic wr_model(input logic [17:0] a, input logic [7:0] d);
    logic [28:0] wa;
    logic [63:0] t;
    wa = BASE + 29'(a >> 3);
    t = mem_rd(wa);
    t[8*a[2:0] +: 8] = d;
    mem[wa] = t;
    if (m_tag == a[17:3]) m_valid = 1'b0;
  endtask

  task automatic wr_txn(input logic [17:0] a, input logic [7:0] d, input int b, input bit poke);
    logic [28:0] wa;
    logic [7:0]  be_e;
    wa   = BASE + 29'(a >> 3);
    be_e = 8'd1 << a[2:0];
    wr_addr = a;
    wr_data = d;
    wr_en = 1'b1;
    DDRAM_BUSY = (b > 0);
    @(negedge clk_sys);
    wr_en = 1'b0;
    chk("wr_we", DDRAM_WE, 64'd1);
    chk("wr_busy_set", wr_busy, 64'd1);
    chk("wr_addr", DDRAM_ADDR, wa);
    chk("wr_be", DDRAM_BE, be_e);
    chk("wr_din", DDRAM_DIN, {8{d}});
    chk("wr_no_rd", DDRAM_RD, 64'd0);
    if (poke) begin
      wr_addr = a ^ 18'h00008;
      wr_data = ~d;
      wr_en = 1'b1;
    end
    for (int k = 0; k < b; k++) begin
      @(negedge clk_sys);
      wr_en = 1'b0;
      chk("wr_stall_we", DDRAM_WE, 64'd1);
      chk("wr_stall_din", DDRAM_DIN, {8{d}});
      chk("wr_stall_busy", wr_busy, 64'd1);
      if (k == b - 1) DDRAM_BUSY = 1'b0;
    end
    @(negedge clk_sys);
    wr_en = 1'b0;
    chk("wr_we_drop", DDRAM_WE, 64'd0);
    chk("wr_busy_clear", wr_busy, 64'd0);
    @(negedge clk_sys);
    chk("wr_no_second_we", DDRAM_WE, 64'd0);
    wr_model(a, d);
  endtask

  initial begin
    int r0;
    logic [28:0] wa;
    logic [63:0] exp;
    reset_n = 1'b0;
    ch_addr = 18'h0; ch_req = 1'b0;
    wr_addr = 18'h0; wr_data = 8'h00; wr_en = 1'b0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = 64'h0; DDRAM_DOUT_READY = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rst_ready", ch_ready, 64'd0);
    chk("rst_dout", ch_dout, 64'd0);
    chk("rst_rd", DDRAM_RD, 64'd0);
    chk("rst_we", DDRAM_WE, 64'd0);
    chk("rst_wr_busy", wr_busy, 64'd0);
    chk("rst_burstcnt", DDRAM_BURSTCNT, 64'd1);
    chk("rst_addr", DDRAM_ADDR, 64'd0);
    chk("rst_be", DDRAM_BE, 64'd0);
    chk("rst_din", DDRAM_DIN, 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Miss, hit, stalled miss.
    mem[29'h0300000] = 64'h1122334455667788;
    rd_txn(18'h00005, 0, 0);
    rd_txn(18'h00007, 0, 0);
    rd_txn(18'h00100, 5, 2);
    rd_txn(18'h00005, 0, 1);

    // Write invalidates the cached word; the re-read must miss.
    wr_txn(18'h00003, 8'hA5, 0, 1'b0);
    chk("model_lane3", mem[29'h0300000], 64'h11223344A5667788);
    rd_txn(18'h00000, 0, 0);
    rd_txn(18'h00002, 0, 0);
    wr_txn(18'h00011, 8'h3C, 2, 1'b1);

    // Simultaneous write and read: write first, then the read, one ready.
    r0 = ready_cnt;
    wa = BASE + 29'(18'h00080 >> 3);
    exp = mem_rd(wa);
    wr_addr = 18'h00040; wr_data = 8'h5A; wr_en = 1'b1;
    ch_addr = 18'h00080; ch_req = 1'b1;
    @(negedge clk_sys);
    wr_en = 1'b0; ch_req = 1'b0;
    chk("sim_we", DDRAM_WE, 64'd1);
    chk("sim_no_rd", DDRAM_RD, 64'd0);
    chk("sim_be", DDRAM_BE, 64'h01);
    @(negedge clk_sys);
    chk("sim_we_drop", DDRAM_WE, 64'd0);
    chk("sim_rd_not_yet", DDRAM_RD, 64'd0);
    chk("sim_busy_clear", wr_busy, 64'd0);
    wr_model(18'h00040, 8'h5A);
    @(negedge clk_sys);
    chk("sim_rd", DDRAM_RD, 64'd1);
    chk("sim_rd_addr", DDRAM_ADDR, wa);
    rd_finish(18'h00080, 0, 0, exp);
    repeat (3) @(negedge clk_sys);
    chk("sim_one_ready", 64'(ready_cnt - r0), 64'd1);

    // Reset during RD_WAIT abandons the access; a late DOUT_READY is ignored.
    wa = BASE + 29'(18'h01000 >> 3);
    exp = mem_rd(wa);
    ch_addr = 18'h01000; ch_req = 1'b1;
    @(negedge clk_sys);
    ch_req = 1'b0;
    chk("rr_rd", DDRAM_RD, 64'd1);
    @(negedge clk_sys);
    chk("rr_wait", DDRAM_RD, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("rr_rst_rd", DDRAM_RD, 64'd0);
    chk("rr_rst_ready", ch_ready, 64'd0);
    chk("rr_rst_addr", DDRAM_ADDR, 64'd0);
    m_valid = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    DDRAM_DOUT = exp; DDRAM_DOUT_READY = 1'b1;
    @(negedge clk_sys);
    DDRAM_DOUT_READY = 1'b0;
    chk("rr_late_ready", ch_ready, 64'd0);
    @(negedge clk_sys);
    chk("rr_late_ready2", ch_ready, 64'd0);
    rd_txn(18'h00080, 0, 0);

    // Randomized mix over a few words so hits, misses and invalidations all occur.
    for (int i = 0; i < 60; i++) begin
      logic [17:0] a;
      a = 18'(($urandom_range(0, 5) << 3) | $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        wr_txn(a, 8'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      else
        rd_txn(a, $urandom_range(0, 2), $urandom_range(0, 2));
      @(negedge clk_sys);
    end

    chk("rd_we_exclusive", 64'(both_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
